// File: rtl/dec4_rr_arbiter.sv
// dec4_rr_arbiter
//   Four-way round-robin arbiter. The winner is held as a 2-bit index, and
//   the one-hot grant bus is a registered 2-to-4 decode of that index. An
//   owner keeps the grant until it drops its request. Every release is
//   followed by one GAP cycle with no grant. The arbiter then returns to
//   IDLE and arbitrates on the next edge.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     When defined, an owner that stays BUSY for HOLD_MAX cycles is forced
//     off, and timeout pulses for the GAP cycle that follows.
//     When undefined, there is no hold limit and timeout is always 0.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      [3:0] level requests; the owner holds its bit for the whole transaction
//   gnt      [3:0] one-hot grant; all-zero when there is no owner
//   gnt_idx  [1:0] index of the current owner; valid only while gnt_vld=1
//   gnt_vld  high while an owner exists (BUSY)
//   timeout  one-cycle pulse on a forced release
module dec4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       win;
  logic [1:0]       k;
  logic             found;
  logic             hold_hit;

  function automatic logic [3:0] dec4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Search starts at ptr and wraps 3 -> 0. The first set bit wins.
  always_comb begin
    win   = 2'd0;
    k     = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k = ptr_q + 2'(i);
      if (!found && req[k]) begin
        win   = k;
        found = 1'b1;
      end
    end
  end

  // The counter reads 0 on the first BUSY cycle. Reaching HOLD_LIM therefore
  // means the owner has already held the grant for HOLD_MAX cycles.
  assign hold_hit = TO_EN && (cnt_q == HOLD_LIM);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = win;
          vld_d   = 1'b1;
          gnt_d   = dec4(win);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // A normal release takes precedence over a coincident timeout.
        if (!req[idx_q]) begin
          state_d = GAP;
          ptr_d   = idx_q + 2'd1;
          vld_d   = 1'b0;
          gnt_d   = 4'b0000;
        end else if (hold_hit) begin
          state_d = GAP;
          ptr_d   = idx_q + 2'd1;
          vld_d   = 1'b0;
          gnt_d   = 4'b0000;
          to_d    = 1'b1;
        end
      end
      GAP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      vld_q   <= 1'b0;
      gnt_q   <= 4'b0000;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_dec4_rr_arbiter.sv
module tb_dec4_rr_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_assert = 0;
  int n_fail   = 0;

  dec4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle. Outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] i,
                         input logic v, input logic t);
    chk({tag, ".gnt"}, gnt, g);
    if (v) chk({tag, ".idx"}, {2'b00, gnt_idx}, {2'b00, i});
    chk({tag, ".vld"}, {3'b000, gnt_vld}, {3'b000, v});
    chk({tag, ".to"},  {3'b000, timeout}, {3'b000, t});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    // Reset values
    chk("rst.gnt", gnt, 4'b0000);
    chk("rst.idx", {2'b00, gnt_idx}, 4'b0000);
    chk("rst.vld", {3'b000, gnt_vld}, 4'b0000);
    chk("rst.to",  {3'b000, timeout}, 4'b0000);
    step();
    rst_n = 1'b1;

    // No requests for 5 cycles
    for (int n = 0; n < 5; n++) begin
      step();
      chk_all("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Single requester 2
    req = 4'b0100;
    step(); chk_all("r2.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(); chk_all("r2.hold",  4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk_all("r2.gap",   4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk_all("r2.idle",  4'b0000, 2'd0, 1'b0, 1'b0);

    // ptr is now 3, so the search wraps to 0 ahead of 2
    req = 4'b0101;
    step(); chk_all("wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Asynchronous reset while BUSY drops gnt at once
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.gnt", gnt, 4'b0000);
    chk("arst.vld", {3'b000, gnt_vld}, 4'b0000);
    req = 4'b0000;
    step();
    rst_n = 1'b1;

    // Round robin with all four requesting. Each owner holds 3 cycles.
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      logic [1:0] o;
      logic [3:0] oh;
      o  = 2'(n % 4);
      oh = 4'b0001 << o;
      step(); chk_all("rr.grant", oh, o, 1'b1, 1'b0);
      step(); chk_all("rr.hold1", oh, o, 1'b1, 1'b0);
      step(); chk_all("rr.hold2", oh, o, 1'b1, 1'b0);
      req[o] = 1'b0;
      step(); chk_all("rr.gap",   4'b0000, 2'd0, 1'b0, 1'b0);
      req[o] = 1'b1;
      step(); chk_all("rr.idle",  4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Two requesters held forever
    do_reset();
    req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int n = 0; n < 4; n++) begin
      logic [1:0] o;
      logic [3:0] oh;
      o  = 2'(n % 2);
      oh = 4'b0001 << o;
      for (int c = 0; c < 4; c++) begin
        step(); chk_all("to.own", oh, o, 1'b1, 1'b0);
      end
      step(); chk_all("to.gap",  4'b0000, 2'd0, 1'b0, 1'b1);
      step(); chk_all("to.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end
`else
    // 300 cycles runs the 8-bit counter past saturation. A wrap would be
    // harmless here, but the owner must never be released.
    for (int n = 0; n < 300; n++) begin
      step(); chk_all("hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Guard against a hang in the stimulus sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
